// File: rtl/branch_jump_target_unit_if.sv
// Decode-stage control-flow target bus: operands in from decode, registered
// targets and next PC out toward the PC-select logic.
interface branch_jump_target_unit_if;
    logic        in_valid;
    logic [31:0] extended_imm;
    logic [31:0] pc_plus_4_b;
    logic [31:0] instruction;
    logic [31:0] pc_plus_4_j;
    logic        branch_taken;
    logic        is_jump;
    logic [31:0] bta;
    logic [31:0] jump_address;
    logic [31:0] next_pc;
    logic        out_valid;

    modport master (
        output in_valid, extended_imm, pc_plus_4_b, instruction, pc_plus_4_j,
               branch_taken, is_jump,
        input  bta, jump_address, next_pc, out_valid
    );

    modport slave (
        input  in_valid, extended_imm, pc_plus_4_b, instruction, pc_plus_4_j,
               branch_taken, is_jump,
        output bta, jump_address, next_pc, out_valid
    );
endinterface

// File: rtl/branch_jump_target_unit.sv
// Branch/jump target computation and next-PC selection, registered with a
// single-cycle latency so results align with the following pipeline stage.
module branch_jump_target_unit (
    input  logic                       clk,
    input  logic                       rst_n,
    branch_jump_target_unit_if.slave   bus
);

    // Word offset scaled to bytes; the add wraps modulo 2^32 by design.
    function automatic logic [31:0] branch_target(
        input logic        [31:0] pc_plus_4,
        input logic signed [31:0] imm
    );
        logic signed [31:0] byte_off;
        byte_off = imm <<< 2;
        return pc_plus_4 + $unsigned(byte_off);
    endfunction

    function automatic logic [31:0] jump_target(
        input logic [3:0]  pc_region,
        input logic [25:0] index
    );
        return {pc_region, index, 2'b00};
    endfunction

    logic signed [31:0] imm_p0;
    logic        [31:0] bta_d;
    logic        [31:0] jump_d;
    logic        [31:0] next_pc_d;

    logic        [31:0] bta_p1_q;
    logic        [31:0] jump_p1_q;
    logic        [31:0] next_pc_p1_q;
    logic               vld_p1_q;

    logic               unused_bits;
    assign unused_bits = ^{bus.instruction[31:26], bus.pc_plus_4_j[27:0]};

    assign imm_p0 = $signed(bus.extended_imm);

    always_comb begin
        bta_d     = branch_target(bus.pc_plus_4_b, imm_p0);
        jump_d    = jump_target(bus.pc_plus_4_j[31:28], bus.instruction[25:0]);
        next_pc_d = bus.pc_plus_4_b;
        if (bus.is_jump) begin
            next_pc_d = jump_d;
        end else if (bus.branch_taken) begin
            next_pc_d = bta_d;
        end
    end

    // ---- stage p0 -> p1 boundary ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bta_p1_q     <= 32'h0000_0000;
            jump_p1_q    <= 32'h0000_0000;
            next_pc_p1_q <= 32'h0000_0000;
            vld_p1_q     <= 1'b0;
        end else begin
            vld_p1_q <= bus.in_valid;
            if (bus.in_valid) begin
                bta_p1_q     <= bta_d;
                jump_p1_q    <= jump_d;
                next_pc_p1_q <= next_pc_d;
            end
        end
    end

    assign bus.bta          = bta_p1_q;
    assign bus.jump_address = jump_p1_q;
    assign bus.next_pc      = next_pc_p1_q;
    assign bus.out_valid    = vld_p1_q;

endmodule

// File: tb/tb_branch_jump_target_unit.sv
// Directed self-checking bench for branch_jump_target_unit.
module tb_branch_jump_target_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    branch_jump_target_unit_if bus ();

    branch_jump_target_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs at the falling edge, then sample 1 time unit after the rising edge.
    task automatic drive(input logic v, input logic [31:0] imm, input logic [31:0] pcb,
                         input logic [31:0] ins, input logic [31:0] pcj,
                         input logic bt, input logic j);
        @(negedge clk);
        bus.in_valid     = v;
        bus.extended_imm = imm;
        bus.pc_plus_4_b  = pcb;
        bus.instruction  = ins;
        bus.pc_plus_4_j  = pcj;
        bus.branch_taken = bt;
        bus.is_jump      = j;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b1, 32'h0000_0010, 32'h1234_5678, 32'hFFFF_FFFF, 32'hA000_0000, 1'b1, 1'b1);
        drive(1'b1, 32'h0000_0020, 32'h8765_4320, 32'h0ABC_DEF0, 32'h5000_0000, 1'b1, 1'b0);
        checks++; if (bus.bta !== 32'h0) begin failures++; $display("FAIL reset_bta got=%h exp=%h", bus.bta, 32'h0); end
        checks++; if (bus.jump_address !== 32'h0) begin failures++; $display("FAIL reset_jump got=%h exp=%h", bus.jump_address, 32'h0); end
        checks++; if (bus.next_pc !== 32'h0) begin failures++; $display("FAIL reset_next_pc got=%h exp=%h", bus.next_pc, 32'h0); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_all_zero;
        rst_n = 1'b1;
        drive(1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.bta !== 32'h0) begin failures++; $display("FAIL zero_bta got=%h exp=%h", bus.bta, 32'h0); end
        checks++; if (bus.jump_address !== 32'h0) begin failures++; $display("FAIL zero_jump got=%h exp=%h", bus.jump_address, 32'h0); end
        checks++; if (bus.next_pc !== 32'h0) begin failures++; $display("FAIL zero_next_pc got=%h exp=%h", bus.next_pc, 32'h0); end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL zero_out_valid got=%b exp=1", bus.out_valid); end
    endtask

    task automatic test_branch_taken;
        drive(1'b1, 32'h0000_0001, 32'h1000_0004, 32'h0000_0001, 32'h7000_0000, 1'b1, 1'b0);
        checks++; if (bus.bta !== 32'h1000_0008) begin failures++; $display("FAIL taken_bta got=%h exp=%h", bus.bta, 32'h1000_0008); end
        checks++; if (bus.jump_address !== 32'h7000_0004) begin failures++; $display("FAIL taken_jump got=%h exp=%h", bus.jump_address, 32'h7000_0004); end
        checks++; if (bus.next_pc !== 32'h1000_0008) begin failures++; $display("FAIL taken_next_pc got=%h exp=%h", bus.next_pc, 32'h1000_0008); end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL taken_out_valid got=%b exp=1", bus.out_valid); end
    endtask

    task automatic test_wrap;
        drive(1'b1, 32'hFFFF_FFFF, 32'h1000_0004, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.bta !== 32'h1000_0000) begin failures++; $display("FAIL backward_bta got=%h exp=%h", bus.bta, 32'h1000_0000); end
        checks++; if (bus.next_pc !== 32'h1000_0000) begin failures++; $display("FAIL backward_next_pc got=%h exp=%h", bus.next_pc, 32'h1000_0000); end
        drive(1'b1, 32'h0000_0001, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.bta !== 32'h0000_0000) begin failures++; $display("FAIL wrap_bta got=%h exp=%h", bus.bta, 32'h0); end
        checks++; if (bus.next_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_next_pc_fallthrough got=%h exp=%h", bus.next_pc, 32'hFFFF_FFFC); end
        // Top offset bits are shifted out; low PC bits pass through untouched.
        drive(1'b1, 32'h4000_0001, 32'h0000_0003, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.bta !== 32'h0000_0007) begin failures++; $display("FAIL shift_drop_bta got=%h exp=%h", bus.bta, 32'h7); end
    endtask

    task automatic test_jump;
        drive(1'b1, 32'h0000_0004, 32'h0000_1000, 32'hFFFF_FFFF, 32'hA000_0000, 1'b1, 1'b1);
        checks++; if (bus.jump_address !== 32'hAFFF_FFFC) begin failures++; $display("FAIL jump_addr got=%h exp=%h", bus.jump_address, 32'hAFFF_FFFC); end
        checks++; if (bus.next_pc !== 32'hAFFF_FFFC) begin failures++; $display("FAIL jump_priority_next_pc got=%h exp=%h", bus.next_pc, 32'hAFFF_FFFC); end
        checks++; if (bus.bta !== 32'h0000_1010) begin failures++; $display("FAIL jump_bta got=%h exp=%h", bus.bta, 32'h0000_1010); end
        drive(1'b1, 32'h0000_0004, 32'h0040_0010, 32'hFFFF_FFFF, 32'hA000_0000, 1'b0, 1'b0);
        checks++; if (bus.next_pc !== 32'h0040_0010) begin failures++; $display("FAIL seq_next_pc got=%h exp=%h", bus.next_pc, 32'h0040_0010); end
        drive(1'b1, 32'h0000_0004, 32'h0040_0010, 32'h0300_0000, 32'h5FFF_FFFF, 1'b0, 1'b1);
        checks++; if (bus.next_pc !== 32'h5C00_0000) begin failures++; $display("FAIL jump_only_next_pc got=%h exp=%h", bus.next_pc, 32'h5C00_0000); end
    endtask

    task automatic test_hold;
        drive(1'b1, 32'h0000_0002, 32'h2000_0000, 32'h0000_0010, 32'h3000_0000, 1'b1, 1'b0);
        checks++; if (bus.bta !== 32'h2000_0008) begin failures++; $display("FAIL hold_cap_bta got=%h exp=%h", bus.bta, 32'h2000_0008); end
        drive(1'b0, 32'h0000_0100, 32'h5555_5550, 32'h03FF_FFFF, 32'hF000_0000, 1'b0, 1'b1);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL hold_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.bta !== 32'h2000_0008) begin failures++; $display("FAIL hold_bta got=%h exp=%h", bus.bta, 32'h2000_0008); end
        checks++; if (bus.jump_address !== 32'h3000_0040) begin failures++; $display("FAIL hold_jump got=%h exp=%h", bus.jump_address, 32'h3000_0040); end
        checks++; if (bus.next_pc !== 32'h2000_0008) begin failures++; $display("FAIL hold_next_pc got=%h exp=%h", bus.next_pc, 32'h2000_0008); end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 32'h0000_0003, 32'h0000_0100, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.next_pc !== 32'h0000_010C || bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_0 got=%h/%b exp=%h/1", bus.next_pc, bus.out_valid, 32'h10C); end
        drive(1'b1, 32'hFFFF_FFFE, 32'h0000_0100, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.next_pc !== 32'h0000_00F8 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_1 got=%h/%b exp=%h/1", bus.next_pc, bus.out_valid, 32'hF8); end
        drive(1'b1, 32'h0, 32'h0000_0200, 32'h0000_0040, 32'h8000_0000, 1'b0, 1'b1);
        checks++; if (bus.next_pc !== 32'h8000_0100 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_2 got=%h/%b exp=%h/1", bus.next_pc, bus.out_valid, 32'h8000_0100); end
    endtask

    task automatic test_reset_midstream;
        drive(1'b1, 32'h0000_0001, 32'h0000_0400, 32'h0, 32'h0, 1'b1, 1'b0);
        rst_n = 1'b0;
        drive(1'b1, 32'h0000_0001, 32'h0000_0800, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.next_pc !== 32'h0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL midreset got=%h/%b exp=%h/0", bus.next_pc, bus.out_valid, 32'h0); end
        rst_n = 1'b1;
        drive(1'b0, 32'h0000_0001, 32'h0000_0C00, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.next_pc !== 32'h0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL post_release_idle got=%h/%b exp=%h/0", bus.next_pc, bus.out_valid, 32'h0); end
        drive(1'b1, 32'h0000_0001, 32'h0000_0C00, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.next_pc !== 32'h0000_0C04 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL post_release_first got=%h/%b exp=%h/1", bus.next_pc, bus.out_valid, 32'hC04); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.in_valid     = 1'b0;
        bus.extended_imm = 32'h0;
        bus.pc_plus_4_b  = 32'h0;
        bus.instruction  = 32'h0;
        bus.pc_plus_4_j  = 32'h0;
        bus.branch_taken = 1'b0;
        bus.is_jump      = 1'b0;
        test_reset();
        test_all_zero();
        test_branch_taken();
        test_wrap();
        test_jump();
        test_hold();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
